// File: rtl/load_store_queue_pkg.sv
// Shared configuration for the load/store queue: instruction type encodings,
// default ROB index width, FSM state encodings and the address helper.
package load_store_queue_pkg;

    // Default ROB index width used by the queue and its snoop sub-module
    localparam int LSQ_ROB_W = 4;

    // inst_type[3] selects store; inst_type[2:0] is the length/sign code
    localparam int TYPE_STORE_BIT = 3;
    localparam logic [2:0] LEN_B  = 3'b000;
    localparam logic [2:0] LEN_H  = 3'b001;
    localparam logic [2:0] LEN_W  = 3'b010;
    localparam logic [2:0] LEN_BU = 3'b100;
    localparam logic [2:0] LEN_HU = 3'b101;

    // Memory-side FSM: DRAIN waits out a transaction whose result was flushed
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } lsq_state_e;

    // Effective address: base plus sign-extended 12-bit offset, wrapping mod 2^32
    function automatic logic [31:0] lsq_eff_addr(input logic [31:0] base,
                                                 input logic [11:0] off);
        return base + {{20{off[11]}}, off};
    endfunction

endpackage

// File: rtl/lsq_operand_snoop.sv
// Resolves one pending operand against every CDB port and the queue's own
// writeback. The lowest-numbered CDB port wins; the local writeback is the
// fallback when no CDB port matches.
module lsq_operand_snoop
    import load_store_queue_pkg::*;
#(
    parameter int ROB_W   = LSQ_ROB_W,
    parameter int NUM_CDB = 2
) (
    input  logic                     i_has_dep,
    input  logic [ROB_W-1:0]         i_dep,
    input  logic [31:0]              i_value,
    input  logic [NUM_CDB-1:0]       i_cdb_valid,
    input  logic [NUM_CDB*ROB_W-1:0] i_cdb_idx,
    input  logic [NUM_CDB*32-1:0]    i_cdb_value,
    input  logic                     i_wb_valid,
    input  logic [ROB_W-1:0]         i_wb_idx,
    input  logic [31:0]              i_wb_value,
    output logic                     o_has_dep,
    output logic [31:0]              o_value
);

    logic w_hit;

    // Priority search for a producer of this operand; no-op when already ready
    always_comb begin
        w_hit   = 1'b0;
        o_value = i_value;
        if (i_has_dep) begin
            for (int k = 0; k < NUM_CDB; k++) begin
                if (!w_hit && i_cdb_valid[k] && (i_cdb_idx[k*ROB_W +: ROB_W] == i_dep)) begin
                    w_hit   = 1'b1;
                    o_value = i_cdb_value[k*32 +: 32];
                end
            end
            if (!w_hit && i_wb_valid && (i_wb_idx == i_dep)) begin
                w_hit   = 1'b1;
                o_value = i_wb_value;
            end
        end
        o_has_dep = i_has_dep && !w_hit;
    end

endmodule

// File: rtl/load_store_queue.sv
// In-order load/store queue. Entries wait in a circular FIFO until both
// operands are known; only the head issues to memory, one transaction at a
// time. Stores additionally wait until they are the ROB head. A flush empties
// the queue but lets an in-flight memory access finish without writeback.
module load_store_queue
    import load_store_queue_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int ROB_W   = LSQ_ROB_W,
    parameter int NUM_CDB = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     rob_clear,
    // issue
    input  logic                     inst_valid,
    input  logic [3:0]               inst_type,
    input  logic [ROB_W-1:0]         inst_rob_idx,
    input  logic [31:0]              inst_r1,
    input  logic [31:0]              inst_r2,
    input  logic [ROB_W-1:0]         inst_dep1,
    input  logic [ROB_W-1:0]         inst_dep2,
    input  logic                     inst_has_dep1,
    input  logic                     inst_has_dep2,
    input  logic [11:0]              inst_offset,
    output logic                     full,
    // ROB head / CDB snoop
    input  logic                     rob_head_valid,
    input  logic [ROB_W-1:0]         rob_head_idx,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*ROB_W-1:0] cdb_idx,
    input  logic [NUM_CDB*32-1:0]    cdb_value,
    // writeback
    output logic                     lsb_wb_valid,
    output logic [ROB_W-1:0]         lsb_wb_idx,
    output logic [31:0]              lsb_wb_value,
    // memory
    output logic                     mem_valid,
    output logic                     mem_wr,
    output logic [2:0]               mem_len,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic                     mem_done,
    input  logic [31:0]              mem_rdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // FSM
    lsq_state_e r_state, w_state_nxt;

    // queue bookkeeping
    logic [PTR_W-1:0] r_head, r_tail;
    logic [CNT_W-1:0] r_count;

    // entry storage
    logic [DEPTH-1:0]            r_busy, r_is_st, r_has1, r_has2;
    logic [DEPTH-1:0][2:0]       r_len;
    logic [DEPTH-1:0][ROB_W-1:0] r_rob, r_dep1, r_dep2;
    logic [DEPTH-1:0][31:0]      r_r1, r_r2;
    logic [DEPTH-1:0][11:0]      r_off;

    // snooped next values for resident entries and for the incoming push
    logic [DEPTH-1:0]       w_has1_nxt, w_has2_nxt;
    logic [DEPTH-1:0][31:0] w_r1_nxt, w_r2_nxt;
    logic                   w_push_has1, w_push_has2;
    logic [31:0]            w_push_r1, w_push_r2;

    // control
    logic w_full, w_push, w_head_ready, w_issue, w_mem_active, w_wb_fire;

    // latched memory transaction
    logic             r_mem_wr;
    logic [2:0]       r_mem_len;
    logic [31:0]      r_mem_addr, r_mem_wdata;
    logic [ROB_W-1:0] r_mem_rob;

    // writeback register
    logic             r_wb_valid;
    logic [ROB_W-1:0] r_wb_idx;
    logic [31:0]      r_wb_value;

    // Operand snoop for the instruction being pushed this cycle
    lsq_operand_snoop #(.ROB_W(ROB_W), .NUM_CDB(NUM_CDB)) u_push_snoop1 (
        .i_has_dep(inst_has_dep1), .i_dep(inst_dep1), .i_value(inst_r1),
        .i_cdb_valid(cdb_valid), .i_cdb_idx(cdb_idx), .i_cdb_value(cdb_value),
        .i_wb_valid(r_wb_valid), .i_wb_idx(r_wb_idx), .i_wb_value(r_wb_value),
        .o_has_dep(w_push_has1), .o_value(w_push_r1)
    );
    lsq_operand_snoop #(.ROB_W(ROB_W), .NUM_CDB(NUM_CDB)) u_push_snoop2 (
        .i_has_dep(inst_has_dep2), .i_dep(inst_dep2), .i_value(inst_r2),
        .i_cdb_valid(cdb_valid), .i_cdb_idx(cdb_idx), .i_cdb_value(cdb_value),
        .i_wb_valid(r_wb_valid), .i_wb_idx(r_wb_idx), .i_wb_value(r_wb_value),
        .o_has_dep(w_push_has2), .o_value(w_push_r2)
    );

    // Two snoopers per resident entry, one per operand
    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
        lsq_operand_snoop #(.ROB_W(ROB_W), .NUM_CDB(NUM_CDB)) u_snoop1 (
            .i_has_dep(r_has1[e]), .i_dep(r_dep1[e]), .i_value(r_r1[e]),
            .i_cdb_valid(cdb_valid), .i_cdb_idx(cdb_idx), .i_cdb_value(cdb_value),
            .i_wb_valid(r_wb_valid), .i_wb_idx(r_wb_idx), .i_wb_value(r_wb_value),
            .o_has_dep(w_has1_nxt[e]), .o_value(w_r1_nxt[e])
        );
        lsq_operand_snoop #(.ROB_W(ROB_W), .NUM_CDB(NUM_CDB)) u_snoop2 (
            .i_has_dep(r_has2[e]), .i_dep(r_dep2[e]), .i_value(r_r2[e]),
            .i_cdb_valid(cdb_valid), .i_cdb_idx(cdb_idx), .i_cdb_value(cdb_value),
            .i_wb_valid(r_wb_valid), .i_wb_idx(r_wb_idx), .i_wb_value(r_wb_value),
            .o_has_dep(w_has2_nxt[e]), .o_value(w_r2_nxt[e])
        );
    end

    // Full flag and push acceptance; a flush swallows the same-cycle push
    always_comb begin
        w_full       = (r_count == CNT_W'(DEPTH));
        w_push       = rdy_in && inst_valid && !w_full && !rob_clear;
        w_head_ready = r_busy[r_head] && !r_has1[r_head] && !r_has2[r_head] &&
                       (!r_is_st[r_head] ||
                        (rob_head_valid && (rob_head_idx == r_rob[r_head])));
    end

    // FSM state register; holds while stalled
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)     r_state <= ST_IDLE;
        else if (rdy_in) r_state <= w_state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_issue) w_state_nxt = ST_WAIT;
            ST_WAIT:  if (mem_done) w_state_nxt = ST_IDLE;
                      else if (rob_clear) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (mem_done) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: issue strobe, bus-active flag, writeback strobe
    always_comb begin
        w_issue      = rdy_in && !rob_clear && (r_state == ST_IDLE) && w_head_ready;
        w_mem_active = (r_state != ST_IDLE);
        w_wb_fire    = rdy_in && (r_state == ST_WAIT) && mem_done && !rob_clear;
    end

    // Queue storage: snoop captures, head pop on issue, tail push, flush
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_busy  <= '0;
            r_is_st <= '0;
            r_has1  <= '0;
            r_has2  <= '0;
            r_len   <= '0;
            r_rob   <= '0;
            r_dep1  <= '0;
            r_dep2  <= '0;
            r_r1    <= '0;
            r_r2    <= '0;
            r_off   <= '0;
        end else if (rdy_in) begin
            if (rob_clear) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_busy  <= '0;
            end else begin
                for (int e = 0; e < DEPTH; e++) begin
                    if (r_busy[e]) begin
                        r_has1[e] <= w_has1_nxt[e];
                        r_has2[e] <= w_has2_nxt[e];
                        r_r1[e]   <= w_r1_nxt[e];
                        r_r2[e]   <= w_r2_nxt[e];
                    end
                end
                if (w_issue) begin
                    r_busy[r_head] <= 1'b0;
                    r_head         <= r_head + PTR_W'(1);
                end
                if (w_push) begin
                    r_busy[r_tail]  <= 1'b1;
                    r_is_st[r_tail] <= inst_type[TYPE_STORE_BIT];
                    r_len[r_tail]   <= inst_type[2:0];
                    r_rob[r_tail]   <= inst_rob_idx;
                    r_dep1[r_tail]  <= inst_dep1;
                    r_dep2[r_tail]  <= inst_dep2;
                    r_has1[r_tail]  <= w_push_has1;
                    r_has2[r_tail]  <= w_push_has2;
                    r_r1[r_tail]    <= w_push_r1;
                    r_r2[r_tail]    <= w_push_r2;
                    r_off[r_tail]   <= inst_offset;
                    r_tail          <= r_tail + PTR_W'(1);
                end
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_issue);
            end
        end
    end

    // Latch the head's transaction at issue; held until the next issue
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_mem_wr    <= 1'b0;
            r_mem_len   <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_rob   <= '0;
        end else if (w_issue) begin
            r_mem_wr    <= r_is_st[r_head];
            r_mem_len   <= r_len[r_head];
            r_mem_addr  <= lsq_eff_addr(r_r1[r_head], r_off[r_head]);
            r_mem_wdata <= r_r2[r_head];
            r_mem_rob   <= r_rob[r_head];
        end
    end

    // One-cycle writeback after an unflushed completion; stores report zero
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wb_valid <= 1'b0;
            r_wb_idx   <= '0;
            r_wb_value <= '0;
        end else if (rdy_in) begin
            r_wb_valid <= w_wb_fire;
            if (w_wb_fire) begin
                r_wb_idx   <= r_mem_rob;
                r_wb_value <= r_mem_wr ? 32'd0 : mem_rdata;
            end
        end
    end

    assign full         = w_full;
    assign mem_valid    = w_mem_active;
    assign mem_wr       = r_mem_wr;
    assign mem_len      = r_mem_len;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign lsb_wb_valid = r_wb_valid;
    assign lsb_wb_idx   = r_wb_idx;
    assign lsb_wb_value = r_wb_value;

endmodule

// File: tb/tb_load_store_queue.sv
// Bench for load_store_queue: directed stimulus, a queue-based reference
// model compared against the outputs every cycle, plus literal expectations.
module tb_load_store_queue;
    import load_store_queue_pkg::*;

    localparam int DEPTH   = 8;
    localparam int ROB_W   = 4;
    localparam int NUM_CDB = 2;
    localparam logic [3:0] T_LW = {1'b0, LEN_W};
    localparam logic [3:0] T_SW = {1'b1, LEN_W};

    logic clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b1, rob_clear = 1'b0;
    logic inst_valid = 1'b0, inst_has_dep1 = 1'b0, inst_has_dep2 = 1'b0;
    logic [3:0] inst_type = '0;
    logic [ROB_W-1:0] inst_rob_idx = '0, inst_dep1 = '0, inst_dep2 = '0;
    logic [31:0] inst_r1 = '0, inst_r2 = '0;
    logic [11:0] inst_offset = '0;
    logic full;
    logic rob_head_valid = 1'b0;
    logic [ROB_W-1:0] rob_head_idx = '0;
    logic [NUM_CDB-1:0] cdb_valid = '0;
    logic [NUM_CDB*ROB_W-1:0] cdb_idx = '0;
    logic [NUM_CDB*32-1:0] cdb_value = '0;
    logic lsb_wb_valid;
    logic [ROB_W-1:0] lsb_wb_idx;
    logic [31:0] lsb_wb_value;
    logic mem_valid, mem_wr;
    logic [2:0] mem_len;
    logic [31:0] mem_addr, mem_wdata;
    logic mem_done = 1'b0;
    logic [31:0] mem_rdata = '0;

    int errors = 0;
    int checks = 0;

    load_store_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W), .NUM_CDB(NUM_CDB)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
        .inst_valid(inst_valid), .inst_type(inst_type), .inst_rob_idx(inst_rob_idx),
        .inst_r1(inst_r1), .inst_r2(inst_r2), .inst_dep1(inst_dep1), .inst_dep2(inst_dep2),
        .inst_has_dep1(inst_has_dep1), .inst_has_dep2(inst_has_dep2),
        .inst_offset(inst_offset), .full(full),
        .rob_head_valid(rob_head_valid), .rob_head_idx(rob_head_idx),
        .cdb_valid(cdb_valid), .cdb_idx(cdb_idx), .cdb_value(cdb_value),
        .lsb_wb_valid(lsb_wb_valid), .lsb_wb_idx(lsb_wb_idx), .lsb_wb_value(lsb_wb_value),
        .mem_valid(mem_valid), .mem_wr(mem_wr), .mem_len(mem_len), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        st;
        logic [2:0]  len;
        logic [3:0]  rob;
        logic [31:0] r1, r2;
        logic [3:0]  d1, d2;
        logic        h1, h2;
        logic [11:0] off;
    } ent_t;

    ent_t mq[$];
    logic m_busy = 1'b0, m_drain = 1'b0, m_wr = 1'b0;
    logic [2:0] m_len = '0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic [3:0] m_rob = '0;
    logic m_wb_v = 1'b0;
    logic [3:0] m_wb_idx = '0;
    logic [31:0] m_wb_val = '0;
    logic mi_issue, mi_full, mi_wb;
    logic [3:0] mi_wb_idx;
    logic [31:0] mi_wb_val;
    ent_t mi_e;

    // Lowest CDB port wins, the queue's own writeback is the last resort
    task automatic resolve(input logic h_i, input logic [3:0] d, input logic [31:0] v_i,
                           output logic h_o, output logic [31:0] v_o);
        h_o = h_i;
        v_o = v_i;
        if (h_i) begin
            for (int k = NUM_CDB - 1; k >= 0; k--)
                if (cdb_valid[k] && cdb_idx[k*ROB_W +: ROB_W] == d) begin
                    h_o = 1'b0;
                    v_o = cdb_value[k*32 +: 32];
                end
            if (h_o && m_wb_v && m_wb_idx == d) begin
                h_o = 1'b0;
                v_o = m_wb_val;
            end
        end
    endtask

    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mq.delete();
            m_busy = 0; m_drain = 0; m_wr = 0; m_len = 0; m_addr = 0; m_wdata = 0;
            m_wb_v = 0; m_wb_idx = 0; m_wb_val = 0;
        end else if (rdy_in) begin
            mi_full  = (mq.size() == DEPTH);
            mi_issue = 1'b0;
            if (!m_busy && !rob_clear && mq.size() > 0) begin
                mi_e = mq[0];
                if (!mi_e.h1 && !mi_e.h2 &&
                    (!mi_e.st || (rob_head_valid && rob_head_idx == mi_e.rob)))
                    mi_issue = 1'b1;
            end
            foreach (mq[i]) begin
                mi_e = mq[i];
                resolve(mi_e.h1, mi_e.d1, mi_e.r1, mi_e.h1, mi_e.r1);
                resolve(mi_e.h2, mi_e.d2, mi_e.r2, mi_e.h2, mi_e.r2);
                mq[i] = mi_e;
            end
            mi_wb = 1'b0; mi_wb_idx = m_wb_idx; mi_wb_val = m_wb_val;
            if (m_busy && mem_done) begin
                mi_wb     = !m_drain && !rob_clear;
                mi_wb_idx = m_rob;
                mi_wb_val = m_wr ? 32'd0 : mem_rdata;
                m_busy = 0; m_drain = 0;
            end else if (m_busy && rob_clear) begin
                m_drain = 1;
            end
            if (rob_clear) mq.delete();
            else begin
                if (mi_issue) begin
                    mi_e = mq.pop_front();
                    m_busy = 1; m_wr = mi_e.st; m_len = mi_e.len; m_rob = mi_e.rob;
                    m_addr = mi_e.r1 + 32'($signed(mi_e.off));
                    m_wdata = mi_e.r2;
                end
                if (inst_valid && !mi_full) begin
                    mi_e.st = inst_type[3]; mi_e.len = inst_type[2:0]; mi_e.rob = inst_rob_idx;
                    mi_e.d1 = inst_dep1; mi_e.d2 = inst_dep2; mi_e.off = inst_offset;
                    resolve(inst_has_dep1, inst_dep1, inst_r1, mi_e.h1, mi_e.r1);
                    resolve(inst_has_dep2, inst_dep2, inst_r2, mi_e.h2, mi_e.r2);
                    mq.push_back(mi_e);
                end
            end
            m_wb_v = mi_wb;
            if (mi_wb) begin m_wb_idx = mi_wb_idx; m_wb_val = mi_wb_val; end
        end
    end

    // Compare process: every cycle, away from the active edge
    always @(negedge clk_in) begin
        chk("full", full, (mq.size() == DEPTH));
        chk("mem_valid", mem_valid, m_busy);
        if (m_busy) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("mem_wr", mem_wr, m_wr);
            chk("mem_len", mem_len, m_len);
        end
        chk("wb_valid", lsb_wb_valid, m_wb_v);
        if (m_wb_v) begin
            chk("wb_idx", lsb_wb_idx, m_wb_idx);
            chk("wb_value", lsb_wb_value, m_wb_val);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push(input logic [3:0] ty, input logic [3:0] rob, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [11:0] off,
                        input logic h1, input logic [3:0] d1);
        inst_valid = 1; inst_type = ty; inst_rob_idx = rob; inst_r1 = r1; inst_r2 = r2;
        inst_offset = off; inst_has_dep1 = h1; inst_dep1 = d1; inst_has_dep2 = 0; inst_dep2 = 0;
        step();
        inst_valid = 0;
    endtask

    task automatic wait_mem(input string name);
        int n = 0;
        while (!mem_valid && n < 20) begin step(); n++; end
        checks++;
        if (!mem_valid) begin
            errors++;
            $display("FAIL %s: mem_valid got 0 expected 1 within 20 cycles", name);
        end
    endtask

    task automatic mem_respond(input logic [31:0] rd);
        mem_done = 1; mem_rdata = rd;
        step();
        mem_done = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset
        repeat (2) step();
        chk("rst mem_valid", mem_valid, 0);
        chk("rst full", full, 0);
        chk("rst wb_valid", lsb_wb_valid, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wr", mem_wr, 0);
        rst_in = 1;
        step();

        // LW r1=0x100 offset=-4
        push(T_LW, 4'd1, 32'h100, 32'h0, 12'hFFC, 0, 0);
        wait_mem("t1");
        chk("t1 addr", mem_addr, 32'hFC);
        chk("t1 len", mem_len, 3'b010);
        chk("t1 wr", mem_wr, 0);
        mem_respond(32'hDEADBEEF);
        chk("t1 wb_valid", lsb_wb_valid, 1);
        chk("t1 wb_value", lsb_wb_value, 32'hDEADBEEF);
        chk("t1 wb_idx", lsb_wb_idx, 1);
        step();
        chk("t1 wb_pulse", lsb_wb_valid, 0);

        // SW waits for ROB head
        rob_head_valid = 1; rob_head_idx = 4'd5;
        push(T_SW, 4'd3, 32'h40, 32'h1234, 12'h008, 0, 0);
        repeat (3) step();
        chk("t2 blocked", mem_valid, 0);
        rob_head_idx = 4'd3;
        wait_mem("t2");
        chk("t2 wr", mem_wr, 1);
        chk("t2 addr", mem_addr, 32'h48);
        chk("t2 wdata", mem_wdata, 32'h1234);
        rob_head_valid = 0;
        mem_respond(32'h77777777);
        chk("t2 wb_valid", lsb_wb_valid, 1);
        chk("t2 wb_value", lsb_wb_value, 0);
        step();

        // dependency resolved from CDB port 1 in the push cycle
        cdb_valid = 2'b10; cdb_idx = {4'd7, 4'd0}; cdb_value = {32'h200, 32'h0};
        push(T_LW, 4'd2, 32'hBAD, 32'h0, 12'h010, 1, 4'd7);
        cdb_valid = 0;
        chk("t3 not_yet", mem_valid, 0);
        step();
        chk("t3 issued", mem_valid, 1);
        chk("t3 addr", mem_addr, 32'h210);
        mem_respond(32'h55);
        step();

        // both CDB ports match: port 0 wins
        cdb_valid = 2'b11; cdb_idx = {4'd6, 4'd6}; cdb_value = {32'hB00, 32'hA00};
        push(T_LW, 4'd4, 32'h0, 32'h0, 12'h000, 1, 4'd6);
        cdb_valid = 0;
        wait_mem("t3b");
        chk("t3b addr", mem_addr, 32'hA00);
        mem_respond(32'h1);
        step();

        // fill to DEPTH, overflow push ignored, resolve and drain across wrap
        for (int k = 0; k < DEPTH; k++)
            push(T_LW, 4'(k), 32'h0, 32'h0, 12'(k * 4), 1, 4'(8 + k));
        chk("t4 full", full, 1);
        push(T_LW, 4'd15, 32'h999, 32'h0, 12'h0, 0, 0);
        chk("t4 still_full", full, 1);
        chk("t4 no_issue", mem_valid, 0);
        for (int j = 0; j < DEPTH / 2; j++) begin
            cdb_valid = 2'b11;
            cdb_idx   = {4'(9 + 2 * j), 4'(8 + 2 * j)};
            cdb_value = {32'(32'h1000 + (2 * j + 1) * 16), 32'(32'h1000 + 2 * j * 16)};
            step();
        end
        cdb_valid = 0;
        for (int k = 0; k < DEPTH; k++) begin
            wait_mem("t4 drain");
            chk("t4 addr", mem_addr, 32'(32'h1000 + k * 16 + k * 4));
            mem_respond(32'(32'hC0 + k));
            chk("t4 wb_idx", lsb_wb_idx, 32'(k));
            chk("t4 wb_value", lsb_wb_value, 32'(32'hC0 + k));
        end
        step();

        // flush during WAIT for a store
        rob_head_valid = 1; rob_head_idx = 4'd4;
        push(T_SW, 4'd4, 32'h300, 32'hAB, 12'h0, 0, 0);
        wait_mem("t5");
        push(T_LW, 4'd5, 32'h0, 32'h0, 12'h0, 1, 4'd12);
        rob_clear = 1;
        step();
        rob_clear = 0;
        chk("t5 drain_valid", mem_valid, 1);
        chk("t5 drain_addr", mem_addr, 32'h300);
        chk("t5 empty", full, 0);
        repeat (2) step();
        mem_respond(32'hFFFF);
        chk("t5 no_wb", lsb_wb_valid, 0);
        chk("t5 idle", mem_valid, 0);
        rob_head_valid = 0;
        push(T_LW, 4'd9, 32'h500, 32'h0, 12'h0, 0, 0);
        wait_mem("t5 after");
        chk("t5 after_addr", mem_addr, 32'h500);
        mem_respond(32'h9);
        chk("t5 after_wb", lsb_wb_idx, 9);

        // flush coinciding with mem_done
        push(T_LW, 4'd10, 32'h600, 32'h0, 12'h0, 0, 0);
        wait_mem("t5b");
        rob_clear = 1; mem_done = 1; mem_rdata = 32'h66;
        step();
        rob_clear = 0; mem_done = 0;
        chk("t5b no_wb", lsb_wb_valid, 0);
        chk("t5b idle", mem_valid, 0);

        // stall freezes everything
        push(T_LW, 4'd11, 32'h700, 32'h0, 12'h0, 0, 0);
        wait_mem("t6");
        rdy_in = 0;
        push(T_LW, 4'd12, 32'h0, 32'h0, 12'h0, 0, 0);
        repeat (2) step();
        chk("t6 held", mem_valid, 1);
        chk("t6 addr", mem_addr, 32'h700);
        rdy_in = 1;
        mem_respond(32'h11);
        rdy_in = 0;
        step();
        chk("t6 wb_frozen", lsb_wb_valid, 1);
        rdy_in = 1;
        step();
        chk("t6 wb_done", lsb_wb_valid, 0);

        // async reset mid-WAIT with a full queue
        push(T_LW, 4'd13, 32'h800, 32'h0, 12'h0, 0, 0);
        wait_mem("t7");
        for (int k = 0; k < DEPTH; k++)
            push(T_LW, 4'(k), 32'h0, 32'h0, 12'h0, 1, 4'd14);
        chk("t7 full", full, 1);
        rst_in = 0;
        #1;
        chk("t7 rst mem_valid", mem_valid, 0);
        chk("t7 rst full", full, 0);
        chk("t7 rst addr", mem_addr, 0);
        chk("t7 rst wb", lsb_wb_valid, 0);
        step();
        rst_in = 1;
        step();
        push(T_LW, 4'd2, 32'h900, 32'h0, 12'h0, 0, 0);
        wait_mem("t7 after");
        chk("t7 after_addr", mem_addr, 32'h900);
        mem_respond(32'h99);
        chk("t7 after_wb", lsb_wb_value, 32'h99);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_queue.md
LOAD_STORE_QUEUE -- requirements
Module: load_store_queue

Interface
REQ-001 SHALL have parameters: DEPTH, 8, queue entries (power of 2, >=2); ROB_W, 4, ROB index width; NUM_CDB, 2, snooped writeback ports.
REQ-002 SHALL have ports: clk_in  in  1  clock; rst_in  in  1  reset, asynchronous, active-low; rdy_in  in  1  global stall when low; rob_clear  in  1  flush.
REQ-003 SHALL have issue ports: inst_valid in 1; inst_type in 4 (bit3=store, [2:0]=len/sign code); inst_rob_idx in ROB_W; inst_r1/inst_r2 in 32; inst_dep1/inst_dep2 in ROB_W; inst_has_dep1/inst_has_dep2 in 1; inst_offset in 12; full out 1.
REQ-004 SHALL have ROB ports rob_head_valid in 1 and rob_head_idx in ROB_W, plus CDB ports cdb_valid in NUM_CDB, cdb_idx in NUM_CDB*ROB_W, and cdb_value in NUM_CDB*32 (port k at slice k).
REQ-005 SHALL have writeback ports: lsb_wb_valid out 1; lsb_wb_idx out ROB_W; lsb_wb_value out 32.
REQ-006 SHALL have memory ports: mem_valid out 1; mem_wr out 1; mem_len out 3; mem_addr out 32; mem_wdata out 32; mem_done in 1 (one-cycle pulse); mem_rdata in 32.

Function
REQ-007 SHALL be an in-order circular FIFO; only the head entry issues; count width clog2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-008 SHALL drive full = (count == DEPTH) combinationally; inst_valid while full is ignored.
REQ-009 SHALL, on push, resolve each operand from any matching CDB port or the same-cycle lsb_wb (lowest CDB index wins, lsb_wb last) and clear has_dep accordingly.
REQ-010 SHALL, every cycle, capture the value into each busy entry operand whose dep matches a valid CDB port or lsb_wb, and clear that has_dep.
REQ-011 SHALL use FSM IDLE/WAIT/DRAIN: IDLE->WAIT on issue; WAIT->IDLE on mem_done; WAIT->DRAIN on rob_clear without mem_done; DRAIN->IDLE on mem_done.
REQ-012 SHALL issue from IDLE when the head is busy, both operands ready, rob_clear low, and either load, or store with rob_head_valid && rob_head_idx == head rob index.
REQ-013 SHALL on issue latch mem_addr = r1 + sign-extended offset (mod 2^32), mem_wdata = r2, mem_wr = type[3], mem_len = type[2:0], and the ROB index, and pop the head in the same cycle.
REQ-014 SHALL hold mem_valid and all latched mem outputs stable from the cycle after issue through the mem_done cycle inclusive, in WAIT and DRAIN.
REQ-015 SHALL assert lsb_wb_valid for exactly one cycle, the cycle after mem_done in WAIT, with the latched ROB index; value = mem_rdata for loads and 0 for stores.
REQ-016 SHALL suppress the writeback for mem_done in DRAIN or coinciding with rob_clear; the in-flight store still completes to memory.
REQ-017 SHALL on rob_clear empty the queue (count, head, tail, all busy = 0) and ignore same-cycle inst_valid.
REQ-018 SHALL accept pushes during WAIT and DRAIN; the next issue is no earlier than the cycle after FSM returns to IDLE.
REQ-019 SHALL freeze all state while rdy_in is low; mem_done does not occur while rdy_in is low.

Reset
REQ-020 SHALL on rst_in low immediately set FSM IDLE, count/head/tail 0, all busy/has_dep 0, and full, mem_valid, lsb_wb_valid, and mem_wr low.
REQ-021 SHALL force mem_addr, mem_wdata, mem_len, lsb_wb_idx, and lsb_wb_value to 0 during reset; a reset mid-transaction abandons it.

Structure
REQ-022 SHALL take type encodings, default ROB_W, and FSM state encodings from the shared config package.
REQ-023 SHALL use one sub-module, lsq_operand_snoop, that resolves dependencies for one operand against all CDB ports and lsb_wb.

Verification
REQ-024 LW r1=0x100, offset=-4, no deps -> mem_valid with addr 0xFC, len 010, wr 0; mem_done with rdata 0xDEADBEEF -> next cycle lsb_wb_valid, value 0xDEADBEEF.
REQ-025 SW idx 3 with rob_head_idx=5 -> no mem_valid; rob_head_idx=3 -> mem_valid, wr 1; wb value 0 the cycle after mem_done.
REQ-026 Load with dep1=7, cdb port1 idx 7 value 0x200 in the push cycle -> issues the next cycle with addr 0x200+offset.
REQ-027 Push DEPTH entries with unresolved deps -> full=1, an extra push is ignored; resolve, then drain -> all DEPTH complete in order across pointer wrap.
REQ-028 rob_clear in WAIT for a store -> DRAIN, mem_valid held, queue empty; mem_done -> no lsb_wb_valid, IDLE.
REQ-029 rst_in low mid-WAIT -> mem_valid=0, full=0, count 0 immediately; with rdy_in low, no state changes.
